hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
Parametrised successor to the HI/LO register pair: holds HI/LO and also computes them with a pipelined multiplier and an iterative radix-2 divider. Sits beside the EX stage. EX issues an op with `start`. The pipeline stalls on `busy`. Results in HI/LO become visible when `done` pulses. MTHI/MTLO still write HI or LO directly. A flush input cancels an in-flight operation on exception or branch-squash.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width (even, ≥ 8).
- MUL_STAGES, 2, multiply latency in cycles (≥ 1).

Ports:
- clk, input, 1, clock (rising edge).
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, issue request, sampled at the rising edge.
- op, input, 3, operation code (package enum).
- operand_a, input, DATA_WIDTH, multiplicand / dividend / MTHI-MTLO data.
- operand_b, input, DATA_WIDTH, multiplier / divisor.
- flush, input, 1, abort in-flight operation.
- busy, output, 1, operation in flight; EX must stall.
- done, output, 1, one-cycle pulse; HI/LO updated this cycle.
- hi, output, DATA_WIDTH, HI register.
- lo, output, DATA_WIDTH, LO register.

Behaviour:
- Reset: rst=0 asynchronously forces hi=0, lo=0, busy=0, done=0 and FSM=IDLE, including mid-operation. Any partial result is discarded.
- Op codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved. NOP and 7 are ignored.
- FSM states: IDLE, MUL, DIV.
- start is accepted only in IDLE with flush=0. start while busy is ignored; the operation in flight is unaffected.
- MTHI / MTLO (IDLE): at the accepting edge, hi (or lo) <= operand_a; the other register is unchanged. No busy, no done.
- MULT / MULTU:
  - Accepting edge = edge 0. IDLE->MUL.
  - busy=1 after edge 0 through edge MUL_STAGES-1.
  - After edge MUL_STAGES: {hi,lo} = full 2*DATA_WIDTH product (signed for MULT, unsigned for MULTU), done=1 for one cycle, busy=0, state=IDLE.
  - MUL_STAGES=1: busy never rises; done pulses after edge 1.
- DIV / DIVU:
  - Accepting edge = edge 0. IDLE->DIV.
  - Operands are latched at edge 0. For signed ops, their absolute values are taken.
  - One quotient bit per cycle for DATA_WIDTH cycles, then one sign-fixup cycle.
  - Total latency DATA_WIDTH+1: done after edge DATA_WIDTH+1, busy high in between.
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Signed MIN / -1: lo = MIN, hi = 0.
- Divide by zero: same latency; lo = all ones, hi = operand_a as latched (raw dividend, both DIV and DIVU).
- Operands may change after the accepting edge; the latched copies are used.
- Flush while busy: the next edge returns FSM to IDLE, busy=0, no done; hi/lo retain their prior values.
- Flush in the same cycle as the final step: flush wins, no update.
- Flush in IDLE: suppresses any start or MTHI/MTLO in that cycle.
- Back-to-back issue: a new start may be presented in the cycle done=1 (state is IDLE) and is accepted at that edge.
- hi/lo change only at: done cycles, MTHI/MTLO edges, reset.

Decomposition:
- Shared package: op enum (width 3), FSM state enum, and a localparam for divide latency (DATA_WIDTH+1).
- One sub-module, `div_iter`. It owns the restoring-divide datapath, its step counter and the sign fixup. Ports: start/abort in, done/quotient/remainder out.
- Multiplier pipeline and HI/LO registers stay in the top module.

Test Plan:
- Reset value / async reset:
  - Reset release → hi=0, lo=0, busy=0, done=0.
  - Drop rst mid-divide (cycle 12) → all outputs 0 immediately, before any clock edge.
- MULT / MULTU (DATA_WIDTH=32, MUL_STAGES=2):
  - MULT a=0xFFFFFFFD (-3), b=5 → done two cycles after issue; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed / unsigned DIV:
  - DIV a=0xFFFFFFF9 (-7), b=2 → busy for 32 cycles, done after edge 33; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100, b=7 → lo=14, hi=2.
- Corner divides:
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234.
- Flush and ignored start:
  - Preload hi=0xAA (MTHI), lo=0xBB (MTLO). Issue DIV, then flush at cycle 10 → busy=0 next cycle, no done, hi=0xAA, lo=0xBB.
  - start with MULT while busy → ignored, original result delivered.
- Back-to-back:
  - Issue MULTU 3×4, then DIV 9/2 in the done cycle → hi:lo = 0:12, then hi=1, lo=4 after 33 more cycles.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op codes, FSM states and divide latency.
package hilo_muldiv_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DIV_FIXUP_CYCLES = 1;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Cycles from the accepting edge to the edge that writes HI/LO.
  function automatic int unsigned div_latency(input int unsigned width);
    return width + DIV_FIXUP_CYCLES;
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// Restoring radix-2 divider: first quotient bit at the start edge, one bit per cycle after,
// then a sign-fixup edge that registers quotient/remainder and pulses done.
module div_iter
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  signed_op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(W);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     rem;
  logic [W-1:0]     quo;
  logic [W-1:0]     dvs;
  logic [W-1:0]     raw_dividend;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [W-1:0]     a_abs_c;
  logic [W-1:0]     b_abs_c;

  assign a_abs_c = (signed_op && dividend[W-1]) ? (~dividend + W'(1)) : dividend;
  assign b_abs_c = (signed_op && divisor[W-1])  ? (~divisor + W'(1))  : divisor;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r, input logic [W-1:0] q,
                                              input logic [W-1:0] d);
    logic [W:0] sh;
    logic [W:0] diff;
    sh   = {r, q[W-1]};
    diff = sh - {1'b0, d};
    if (diff[W]) return {sh[W-1:0], q[W-2:0], 1'b0};
    else         return {diff[W-1:0], q[W-2:0], 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running      <= 1'b0;
      done         <= 1'b0;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      raw_dividend <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
    end else if (abort) begin
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      running      <= 1'b1;
      done         <= 1'b0;
      cnt          <= CNT_W'(W - 1);
      {rem, quo}   <= div_step('0, a_abs_c, b_abs_c);
      dvs          <= b_abs_c;
      raw_dividend <= dividend;
      neg_q        <= signed_op & (dividend[W-1] ^ divisor[W-1]);
      neg_r        <= signed_op & dividend[W-1];
      div_zero     <= (divisor == '0);
    end else begin
      done <= 1'b0;
      if (running) begin
        if (cnt != '0) begin
          {rem, quo} <= div_step(rem, quo, dvs);
          cnt        <= cnt - CNT_W'(1);
        end else begin
          running <= 1'b0;
          done    <= 1'b1;
          if (div_zero) begin
            quotient  <= '1;
            remainder <= raw_dividend;
          end else begin
            quotient  <= neg_q ? (~quo + W'(1)) : quo;
            remainder <= neg_r ? (~rem + W'(1)) : rem;
          end
        end
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a pipelined multiplier and an iterative divider beside EX.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W       = DATA_WIDTH;
  localparam int unsigned DIV_LAT = div_latency(W);
  localparam int unsigned LAT_MAX = (DIV_LAT > MUL_STAGES) ? DIV_LAT : MUL_STAGES;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

  op_t              op_e;
  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             busy_d, done_d;
  logic [W-1:0]     hi_d, lo_d;
  logic             div_start, div_abort;
  logic             div_done;
  logic [W-1:0]     div_quo, div_rem;
  logic             mul_signed;
  logic [2*W-1:0]   mul_a, mul_b, mul_prod;
  logic [2*W-1:0]   mul_pipe [MUL_STAGES];

  assign op_e       = op_t'(op);
  assign mul_signed = (op_e == OP_MULT);
  assign mul_a      = {{W{mul_signed & operand_a[W-1]}}, operand_a};
  assign mul_b      = {{W{mul_signed & operand_b[W-1]}}, operand_b};
  assign mul_prod   = mul_a * mul_b;

  // Free-running product pipeline; stage k holds the accepted product after edge k.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(MUL_STAGES); i++) mul_pipe[i] <= '0;
    end else begin
      mul_pipe[0] <= mul_prod;
      for (int i = 1; i < int'(MUL_STAGES); i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  div_iter #(.DATA_WIDTH(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (div_abort),
    .signed_op (op_e == OP_DIV),
    .dividend  (operand_a),
    .divisor   (operand_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      busy  <= busy_d;
      done  <= done_d;
      hi    <= hi_d;
      lo    <= lo_d;
    end
  end

  // busy drops one cycle before the result edge, so it covers latency-1 cycles.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    hi_d      = hi;
    lo_d      = lo;
    div_start = 1'b0;
    div_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          case (op_e)
            OP_MULT, OP_MULTU: begin
              state_d = ST_MUL;
              cnt_d   = CNT_W'(MUL_STAGES - 1);
              busy_d  = (MUL_STAGES > 1);
            end
            OP_DIV, OP_DIVU: begin
              state_d   = ST_DIV;
              cnt_d     = CNT_W'(DIV_LAT - 1);
              busy_d    = 1'b1;
              div_start = 1'b1;
            end
            OP_MTHI: hi_d = operand_a;
            OP_MTLO: lo_d = operand_a;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt == '0) begin
          {hi_d, lo_d} = mul_pipe[MUL_STAGES-1];
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d  = cnt - CNT_W'(1);
          busy_d = (cnt != CNT_W'(1));
        end
      end
      ST_DIV: begin
        if (flush) begin
          div_abort = 1'b1;
          state_d   = ST_IDLE;
        end else if (div_done) begin
          hi_d    = div_rem;
          lo_d    = div_quo;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt - CNT_W'(1);
          busy_d = (cnt != CNT_W'(1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: vector table for mul/div results plus flush, busy-start,
// back-to-back and async-reset sequences.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  hilo_muldiv #(.DATA_WIDTH(32), .MUL_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one start cycle; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  // Waits for done, counting edges after the accepting edge and busy cycles on the way.
  task automatic wait_done(input int first_k, output int lat, output int busy_n);
    lat = -1;
    busy_n = 0;
    for (int k = first_k; k < 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_n++;
      @(negedge clk);
    end
  endtask

  int lat, busy_n, seen;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; operand_a = '0; operand_b = '0;

    vecs[0]  = '{3'(OP_MULT),  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 2};
    vecs[1]  = '{3'(OP_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
    vecs[2]  = '{3'(OP_DIV),   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{3'(OP_DIVU),  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[4]  = '{3'(OP_DIV),   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[5]  = '{3'(OP_DIVU),  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 33};
    vecs[6]  = '{3'(OP_DIV),   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 33};
    vecs[7]  = '{3'(OP_DIV),   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[8]  = '{3'(OP_MULT),  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2};
    vecs[9]  = '{3'(OP_DIV),   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 33};
    vecs[10] = '{3'(OP_DIVU),  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
    vecs[11] = '{3'(OP_MULT),  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 2};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset hi", 64'(hi), 64'h0);
    check("reset lo", 64'(lo), 64'h0);
    check("reset busy", 64'(busy), 64'h0);
    check("reset done", 64'(done), 64'h0);

    // MTHI / MTLO preload
    issue(3'(OP_MTHI), 32'hAA, 32'h0);
    check("mthi hi", 64'(hi), 64'hAA);
    check("mthi lo", 64'(lo), 64'h0);
    check("mthi busy", 64'(busy), 64'h0);
    check("mthi done", 64'(done), 64'h0);
    issue(3'(OP_MTLO), 32'hBB, 32'h0);
    check("mtlo hi", 64'(hi), 64'hAA);
    check("mtlo lo", 64'(lo), 64'hBB);

    // Flush in IDLE suppresses start; reserved op ignored
    flush = 1'b1;
    issue(3'(OP_MTHI), 32'h55, 32'h0);
    check("idle flush mthi hi", 64'(hi), 64'hAA);
    issue(3'(OP_DIV), 32'd9, 32'd2);
    flush = 1'b0;
    check("idle flush div busy", 64'(busy), 64'h0);
    issue(3'(OP_RSVD), 32'h77, 32'h1);
    check("rsvd busy", 64'(busy), 64'h0);
    check("rsvd hi", 64'(hi), 64'hAA);
    check("rsvd lo", 64'(lo), 64'hBB);

    // Flush mid-divide at cycle 10
    issue(3'(OP_DIV), 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    check("mid flush busy before", 64'(busy), 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("mid flush busy", 64'(busy), 64'h0);
    check("mid flush done", 64'(done), 64'h0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    check("mid flush no done", 64'(seen), 64'h0);
    check("mid flush hi", 64'(hi), 64'hAA);
    check("mid flush lo", 64'(lo), 64'hBB);

    // Flush coinciding with the final divide step
    issue(3'(OP_DIVU), 32'd100, 32'd7);
    repeat (32) @(negedge clk);
    check("final flush done before", 64'(done), 64'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = 0;
    repeat (5) begin if (done) seen++; @(negedge clk); end
    check("final flush no done", 64'(seen), 64'h0);
    check("final flush hi", 64'(hi), 64'hAA);
    check("final flush lo", 64'(lo), 64'hBB);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, lat, busy_n);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d busy cycles", i), 64'(busy_n), 64'(vecs[i].lat - 1));
      check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
      @(negedge clk);
      check($sformatf("vec%0d done pulse", i), 64'(done), 64'h0);
    end

    // Start while busy is ignored
    issue(3'(OP_DIVU), 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'(OP_MULT); operand_a = 32'd2; operand_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat, busy_n);
    check("busy start latency", 64'(lat), 64'd33);
    check("busy start hi", 64'(hi), 64'd2);
    check("busy start lo", 64'(lo), 64'd14);
    seen = 0;
    repeat (4) begin @(negedge clk); if (done || busy) seen++; end
    check("busy start no extra op", 64'(seen), 64'h0);

    // Back-to-back: DIV issued in the MULTU done cycle
    issue(3'(OP_MULTU), 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    check("b2b mul done", 64'(done), 64'h1);
    check("b2b mul hilo", {hi, lo}, 64'd12);
    start = 1'b1; op = 3'(OP_DIV); operand_a = 32'd9; operand_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("b2b div busy", 64'(busy), 64'h1);
    wait_done(0, lat, busy_n);
    check("b2b div latency", 64'(lat), 64'd33);
    check("b2b div hi", 64'(hi), 64'd1);
    check("b2b div lo", 64'(lo), 64'd4);

    // Async reset mid-divide
    issue(3'(OP_DIV), 32'h12345678, 32'd3);
    repeat (11) @(negedge clk);
    check("areset busy before", 64'(busy), 64'h1);
    #2 rst = 1'b0;
    #1;
    check("areset hi", 64'(hi), 64'h0);
    check("areset lo", 64'(lo), 64'h0);
    check("areset busy", 64'(busy), 64'h0);
    check("areset done", 64'(done), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen++; end
    check("areset stays idle", 64'(seen), 64'h0);
    check("areset hilo kept", {hi, lo}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
